// File: rtl/upsample_nn_multiple_cores.sv
// Nearest-neighbour 2x upsampler: reads one pooled word per lane and writes it to the
// four pixels of the matching 2x2 output block. Runs 6 cycles per input pixel (RD, CAP, 4x WR).
module upsample_nn_multiple_cores #(
  parameter int IN_ADDR_W       = 11,
  parameter int OUT_ADDR_W      = 11,
  parameter int DATA_W          = 16,
  parameter int STATE_W         = 4,
  parameter int UPS1_STATE      = 12,
  parameter int UPS2_STATE      = 13,
  parameter int UPS1_IN_SIZE    = 7,
  parameter int UPS2_IN_SIZE    = 18,
  parameter int COMPUTING_CORES = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [STATE_W-1:0]                  state,
  input  logic [COMPUTING_CORES-1:0]          core_mask,
  output logic [IN_ADDR_W-1:0]                rd_addr,
  input  logic [COMPUTING_CORES*DATA_W-1:0]   rd_data,
  output logic [COMPUTING_CORES-1:0]          wr_ena,
  output logic [OUT_ADDR_W-1:0]               wr_addr,
  output logic [COMPUTING_CORES*DATA_W-1:0]   wr_data,
  output logic                                done
);

  localparam logic [STATE_W-1:0] UPS1_CODE = STATE_W'(UPS1_STATE);
  localparam logic [STATE_W-1:0] UPS2_CODE = STATE_W'(UPS2_STATE);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} fsm_e;

  fsm_e fsm_q, fsm_d;

  logic                                stage_q, stage_d;
  logic [COMPUTING_CORES-1:0]          mask_q, mask_d;
  logic [7:0]                          r_q, r_d, c_q, c_d;
  logic [1:0]                          q_q, q_d;
  logic [COMPUTING_CORES*DATA_W-1:0]   hold_q, hold_d;
  logic [IN_ADDR_W-1:0]                rd_addr_q, rd_addr_d;
  logic [COMPUTING_CORES-1:0]          wr_ena_q, wr_ena_d;
  logic [OUT_ADDR_W-1:0]               wr_addr_q, wr_addr_d;
  logic [COMPUTING_CORES*DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                                done_q, done_d;

  logic                                is_ups1, is_ups2, start, abort;
  logic                                last_c, last_r;
  logic [STATE_W-1:0]                  stage_code;
  logic [7:0]                          in_sz, out_sz;

  assign is_ups1    = (state == UPS1_CODE);
  assign is_ups2    = (state == UPS2_CODE);
  assign start      = is_ups1 || is_ups2;
  assign stage_code = stage_q ? UPS2_CODE : UPS1_CODE;
  assign abort      = (state != stage_code);
  // Size follows stage_d so the IDLE->RD address already uses the new job's geometry.
  assign in_sz      = stage_d ? 8'(UPS2_IN_SIZE) : 8'(UPS1_IN_SIZE);
  assign out_sz     = {in_sz[6:0], 1'b0};
  assign last_c     = (c_q == in_sz - 8'd1);
  assign last_r     = (r_q == in_sz - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (start) fsm_d = RD;
      RD:   fsm_d = abort ? IDLE : CAP;
      CAP:  fsm_d = abort ? IDLE : WR;
      WR: begin
        if (abort)                  fsm_d = IDLE;
        else if (q_q == 2'd3)       fsm_d = (last_c && last_r) ? FIN : RD;
      end
      FIN:  if (abort) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    mask_d  = mask_q;
    r_d     = r_q;
    c_d     = c_q;
    q_d     = q_q;
    hold_d  = hold_q;
    case (fsm_q)
      IDLE: if (start) begin
        stage_d = is_ups2;
        mask_d  = core_mask;
        r_d     = 8'd0;
        c_d     = 8'd0;
        q_d     = 2'd0;
      end
      CAP: begin
        hold_d = rd_data;
        q_d    = 2'd0;
      end
      WR: if (!abort) begin
        q_d = q_q + 2'd1;
        if (q_q == 2'd3) begin
          if (!last_c) c_d = c_q + 8'd1;
          else begin
            c_d = 8'd0;
            if (!last_r) r_d = r_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    // Output registers are loaded from next-state so they line up with the state they describe.
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_ena_d  = '0;
    if (fsm_d == RD)
      rd_addr_d = IN_ADDR_W'(32'(r_d) * 32'(in_sz) + 32'(c_d));
    if (fsm_d == WR) begin
      wr_ena_d  = mask_d;
      wr_data_d = hold_d;
      wr_addr_d = OUT_ADDR_W'((32'(r_d) * 32'd2 + 32'(q_d[1])) * 32'(out_sz)
                              + 32'(c_d) * 32'd2 + 32'(q_d[0]));
    end
    done_d = (fsm_d == FIN) && (fsm_q != FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q   <= 1'b0;
      mask_q    <= '0;
      r_q       <= '0;
      c_q       <= '0;
      q_q       <= '0;
      hold_q    <= '0;
      rd_addr_q <= '0;
      wr_ena_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      mask_q    <= mask_d;
      r_q       <= r_d;
      c_q       <= c_d;
      q_q       <= q_d;
      hold_q    <= hold_d;
      rd_addr_q <= rd_addr_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;

endmodule

// File: tb/tb_upsample_nn_multiple_cores.sv
// Directed bench for upsample_nn_multiple_cores: full stage-1/stage-2 jobs, abort, reset, hold-after-done.
module tb_upsample_nn_multiple_cores;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic [3:0]  core_mask;
  logic [10:0] rd_addr;
  logic [63:0] rd_data;
  logic [3:0]  wr_ena;
  logic [10:0] wr_addr;
  logic [63:0] wr_data;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int lane_mode = 0;

  logic [10:0] log_addr [0:1295];
  logic [63:0] log_data [0:1295];
  logic [3:0]  log_ena  [0:1295];
  int nwr, seq_err, dup, done_cnt, done_at;

  upsample_nn_multiple_cores dut (
    .clk(clk), .reset(reset), .state(state), .core_mask(core_mask),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_ena(wr_ena),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_data(input int k, input int mode);
    logic [63:0] v;
    for (int i = 0; i < 4; i++)
      v[16*i +: 16] = 16'((mode != 0) ? (4096 * i + k) : k);
    return v;
  endfunction

  // Input BRAM: one-cycle read latency.
  always @(posedge clk) rd_data <= mk_data(int'(rd_addr), lane_mode);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Runs one whole job from IDLE, logging writes and checking every cycle against the address model.
  task automatic run_job(input logic [3:0] code, input logic [3:0] mask, input int in_sz);
    int out_sz, total, k, ph, q, r, c, ea;
    bit written [0:1295];
    out_sz = 2 * in_sz;
    total  = 6 * in_sz * in_sz + 1;
    nwr = 0; seq_err = 0; dup = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 1296; i++) written[i] = 1'b0;
    @(negedge clk);
    state = code; core_mask = mask;
    for (int n = 1; n <= total + 2; n++) begin
      @(posedge clk); #1;
      k  = (n - 1) / 6;
      ph = (n - 1) % 6;
      if (done) begin done_cnt++; done_at = n; end
      if (n < total && ph == 0 && int'(rd_addr) != k) seq_err++;
      if (n < total && ph >= 2) begin
        q = ph - 2; r = k / in_sz; c = k % in_sz;
        ea = (2 * r + q / 2) * out_sz + 2 * c + q % 2;
        if (wr_ena !== mask || int'(wr_addr) != ea || wr_data !== mk_data(k, lane_mode)) seq_err++;
        if (written[wr_addr]) dup++;
        written[wr_addr] = 1'b1;
        if (nwr < 1296) begin
          log_addr[nwr] = wr_addr; log_data[nwr] = wr_data; log_ena[nwr] = wr_ena;
          nwr++;
        end
      end else if (wr_ena !== 4'b0000) seq_err++;
    end
  endtask

  initial begin
    int errs;
    logic [10:0] rd_hold;
    reset = 1'b0; state = 4'd0; core_mask = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_wr_ena",  wr_ena, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_done",    done, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Stage 1, all lanes, same value on every lane
    lane_mode = 0;
    run_job(4'd12, 4'b1111, 7);
    check_eq("s1_seq_err", seq_err, 0);
    check_eq("s1_nwr", nwr, 196);
    check_eq("s1_dup", dup, 0);
    check_eq("s1_done_cnt", done_cnt, 1);
    check_eq("s1_done_at", done_at, 295);
    check_eq("s1_w0_addr", log_addr[0], 0);
    check_eq("s1_w1_addr", log_addr[1], 1);
    check_eq("s1_w2_addr", log_addr[2], 14);
    check_eq("s1_w3_addr", log_addr[3], 15);
    check_eq("s1_w0_data", log_data[0], 64'h0);
    check_eq("s1_p48_a0", log_addr[192], 180);
    check_eq("s1_p48_a1", log_addr[193], 181);
    check_eq("s1_p48_a2", log_addr[194], 194);
    check_eq("s1_p48_a3", log_addr[195], 195);
    check_eq("s1_p48_data", log_data[195], 64'h0030_0030_0030_0030);

    // Hold in FIN with the stage code still present
    rd_hold = rd_addr;
    errs = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (wr_ena !== 4'b0000 || done !== 1'b0 || rd_addr !== rd_hold) errs++;
    end
    check_eq("hold_quiet", errs, 0);
    check_eq("hold_rd_addr", rd_addr, 48);
    @(negedge clk) state = 4'd0;
    repeat (3) @(negedge clk);

    // Stage 2, lanes 0/1 only, distinct per-lane data
    lane_mode = 1;
    run_job(4'd13, 4'b0011, 18);
    check_eq("s2_seq_err", seq_err, 0);
    check_eq("s2_nwr", nwr, 1296);
    check_eq("s2_dup", dup, 0);
    check_eq("s2_done_cnt", done_cnt, 1);
    check_eq("s2_done_at", done_at, 1945);
    check_eq("s2_ena_first", log_ena[0], 4'b0011);
    check_eq("s2_ena_last", log_ena[1295], 4'b0011);
    check_eq("s2_last_a0", log_addr[1292], 1258);
    check_eq("s2_last_a1", log_addr[1293], 1259);
    check_eq("s2_last_a2", log_addr[1294], 1294);
    check_eq("s2_last_a3", log_addr[1295], 1295);
    check_eq("s2_lane_data", log_data[1295], 64'h3143_2143_1143_0143);
    check_eq("s2_lane_data5", log_data[20], 64'h3005_2005_1005_0005);
    @(negedge clk) state = 4'd0;
    repeat (3) @(negedge clk);

    // Abort in WR q=2 of pixel 10 (cycle 65)
    lane_mode = 0;
    state = 4'd12; core_mask = 4'b1111;
    for (int n = 1; n <= 65; n++) begin @(posedge clk); #1; end
    check_eq("abort_pre_ena", wr_ena, 4'b1111);
    check_eq("abort_pre_addr", wr_addr, 48);
    state = 4'd0;
    @(posedge clk); #1;
    check_eq("abort_ena", wr_ena, 4'b0000);
    errs = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (wr_ena !== 4'b0000 || done !== 1'b0) errs++;
    end
    check_eq("abort_quiet", errs, 0);

    // Restart, then async reset in the CAP cycle of pixel 2 (cycle 14)
    @(negedge clk) state = 4'd12;
    @(posedge clk); #1;
    check_eq("restart_rd_addr", rd_addr, 0);
    for (int n = 2; n <= 14; n++) begin @(posedge clk); #1; end
    check_eq("cap_rd_addr", rd_addr, 2);
    check_eq("cap_wr_addr", wr_addr, 17);
    check_eq("cap_wr_data", wr_data, 64'h0001_0001_0001_0001);
    reset = 1'b0;
    #1;
    check_eq("arst_rd_addr", rd_addr, 0);
    check_eq("arst_wr_addr", wr_addr, 0);
    check_eq("arst_wr_data", wr_data, 0);
    check_eq("arst_wr_ena",  wr_ena, 0);
    check_eq("arst_done",    done, 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_rd_addr", rd_addr, 0);
    check_eq("post_rst_ena_rd", wr_ena, 0);
    repeat (2) begin @(posedge clk); #1; end
    check_eq("post_rst_wr_ena", wr_ena, 4'b1111);
    check_eq("post_rst_wr_addr", wr_addr, 0);
    repeat (5) begin @(posedge clk); #1; end
    check_eq("post_rst_rd1", rd_addr, 1);
    state = 4'd0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
